elevator_scan_ctrl: RTL and testbench

Parametrised multi-floor elevator controller and successor to the single-target elevator FSM. It latches any number of floor calls into a pending bitmap and serves them in SCAN order: it continues in the current direction while calls remain ahead, then reverses. It adds a timed door-open dwell at each served floor. It drives the floor index to the existing 7-segment decoder, plus status flags.

---
 rtl/elevator_scan_ctrl.sv | 152 +++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scan_ctrl.sv
// Multi-floor elevator controller: latches floor calls into a pending bitmap and
// serves them in SCAN order with a timed travel per floor and a door-open dwell.
module elevator_scan_ctrl #(
    parameter int unsigned NUM_FLOORS   = 10,
    parameter int unsigned FLOOR_W      = 4,
    parameter int unsigned TRAVEL_TICKS = 10000000,
    parameter int unsigned DOOR_TICKS   = 20000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic                  idle
);

    localparam int unsigned MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int unsigned CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_DOOR_OPEN
    } state_t;

    state_t                  state_q, state_d;
    logic [FLOOR_W-1:0]      floor_d;
    logic [NUM_FLOORS-1:0]   pending_d;
    logic                    dir_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [NUM_FLOORS-1:0]   eff;
    logic [NUM_FLOORS-1:0]   cur_oh;
    logic [NUM_FLOORS-1:0]   next_oh;
    logic [NUM_FLOORS-1:0]   clr;
    logic [FLOOR_W-1:0]      f_next;
    logic                    above;
    logic                    below;
    logic                    here;
    logic                    next_hit;

    // Call view including this cycle's requests, and where calls lie relative to the car
    always_comb begin
        eff     = pending | call_req;
        f_next  = (state_q == S_MOVE_DOWN) ? current_floor - FLOOR_W'(1)
                                           : current_floor + FLOOR_W'(1);
        cur_oh  = '0;
        next_oh = '0;
        above   = 1'b0;
        below   = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            cur_oh[i]  = (current_floor == FLOOR_W'(i));
            next_oh[i] = (f_next == FLOOR_W'(i));
            if (FLOOR_W'(i) > current_floor) above = above | eff[i];
            if (FLOOR_W'(i) < current_floor) below = below | eff[i];
        end
        here     = |(eff & cur_oh);
        next_hit = |(eff & next_oh);
    end

    // Next-state: IDLE and door-close share the same SCAN direction preference
    always_comb begin
        state_d = state_q;
        floor_d = current_floor;
        dir_d   = dir_up;
        cnt_d   = cnt_q;
        clr     = '0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (here) begin
                    state_d = S_DOOR_OPEN;
                    clr     = cur_oh;
                end else if (above && (dir_up || !below)) begin
                    state_d = S_MOVE_UP;
                    dir_d   = 1'b1;
                end else if (below) begin
                    state_d = S_MOVE_DOWN;
                    dir_d   = 1'b0;
                end
            end

            S_MOVE_UP, S_MOVE_DOWN: begin
                if (cnt_q == TRAVEL_LAST) begin
                    cnt_d   = '0;
                    floor_d = f_next;
                    if (next_hit) begin
                        state_d = S_DOOR_OPEN;
                        clr     = next_oh;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DOOR_OPEN: begin
                clr = cur_oh;
                if (here) begin
                    cnt_d = '0;
                end else if (cnt_q == DOOR_LAST) begin
                    cnt_d = '0;
                    if (above && (dir_up || !below)) begin
                        state_d = S_MOVE_UP;
                        dir_d   = 1'b1;
                    end else if (below) begin
                        state_d = S_MOVE_DOWN;
                        dir_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        pending_d = eff & ~clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            current_floor <= '0;
            pending       <= '0;
            dir_up        <= 1'b1;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            current_floor <= floor_d;
            pending       <= pending_d;
            dir_up        <= dir_d;
            cnt_q         <= cnt_d;
        end
    end

    assign moving    = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DOWN);
    assign door_open = (state_q == S_DOOR_OPEN);
    assign idle      = (state_q == S_IDLE);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: directed scenarios plus random calls, every cycle
// compared against a countdown-based behavioural model of the SCAN rules.
module tb_elevator_scan_ctrl;

    localparam int NF = 8;
    localparam int FW = 3;
    localparam int TT = 4;
    localparam int DT = 3;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;
    localparam int M_DOOR = 3;

    logic          clk;
    logic          rst_n;
    logic [NF-1:0] call_req;
    logic [FW-1:0] current_floor;
    logic [NF-1:0] pending;
    logic          dir_up;
    logic          moving;
    logic          door_open;
    logic          idle;

    elevator_scan_ctrl #(
        .NUM_FLOORS  (NF),
        .FLOOR_W     (FW),
        .TRAVEL_TICKS(TT),
        .DOOR_TICKS  (DT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .call_req     (call_req),
        .current_floor(current_floor),
        .pending      (pending),
        .dir_up       (dir_up),
        .moving       (moving),
        .door_open    (door_open),
        .idle         (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    int            m_floor;
    int            m_mode;
    int            m_left;
    bit            m_dir;
    logic [NF-1:0] m_pend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_floor = 0;
        m_pend  = '0;
        m_dir   = 1'b1;
        m_mode  = M_IDLE;
        m_left  = 0;
    endtask

    // Prefer continuing in the current direction, else reverse, else rest
    task automatic plan_move(input bit above, input bit below);
        if (above && (m_dir || !below)) begin
            m_mode = M_UP;
            m_dir  = 1'b1;
            m_left = TT;
        end else if (below) begin
            m_mode = M_DOWN;
            m_dir  = 1'b0;
            m_left = TT;
        end else begin
            m_mode = M_IDLE;
            m_left = 0;
        end
    endtask

    task automatic model_step(input logic [NF-1:0] req);
        logic [NF-1:0] eff;
        logic [NF-1:0] clr;
        bit            above;
        bit            below;
        eff   = m_pend | req;
        clr   = '0;
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NF; i++) begin
            if (i > m_floor) above = above | eff[i];
            if (i < m_floor) below = below | eff[i];
        end
        case (m_mode)
            M_IDLE: begin
                if (eff[m_floor]) begin
                    m_mode       = M_DOOR;
                    m_left       = DT;
                    clr[m_floor] = 1'b1;
                end else begin
                    plan_move(above, below);
                end
            end
            M_UP, M_DOWN: begin
                m_left--;
                if (m_left == 0) begin
                    m_floor += (m_mode == M_UP) ? 1 : -1;
                    m_left   = TT;
                    if (eff[m_floor]) begin
                        m_mode       = M_DOOR;
                        m_left       = DT;
                        clr[m_floor] = 1'b1;
                    end
                end
            end
            default: begin
                clr[m_floor] = 1'b1;
                if (eff[m_floor]) begin
                    m_left = DT;
                end else begin
                    m_left--;
                    if (m_left == 0) plan_move(above, below);
                end
            end
        endcase
        m_pend = eff & ~clr;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".floor"},   32'(current_floor), 32'(m_floor));
        chk({tag, ".pending"}, 32'(pending),       32'(m_pend));
        chk({tag, ".dir_up"},  32'(dir_up),        32'(m_dir));
        chk({tag, ".moving"},  32'(moving),        32'((m_mode == M_UP) || (m_mode == M_DOWN)));
        chk({tag, ".door"},    32'(door_open),     32'(m_mode == M_DOOR));
        chk({tag, ".idle"},    32'(idle),          32'(m_mode == M_IDLE));
    endtask

    task automatic tick(input logic [NF-1:0] req, input string tag);
        call_req = req;
        @(posedge clk);
        model_step(req);
        #1;
        compare_all(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic do_reset(input string tag);
        call_req = '0;
        rst_n    = 1'b0;
        #2;
        model_reset();
        compare_all(tag);
        #1;
        rst_n = 1'b1;
    endtask

    int            doors[$];
    bit            prev_door;
    int            prev_floor;
    int            wrapped;
    logic [NF-1:0] r;

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        call_req = '0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all("por");
        chk("por_idle", 32'(idle), 32'd1);
        chk("por_dir",  32'(dir_up), 32'd1);
        rst_n = 1'b1;

        // Get the car moving, then reset it asynchronously
        tick(8'h10, "pre");
        repeat (5) tick(8'h00, "pre");
        chk("pre_moving", 32'(moving), 32'd1);
        do_reset("async_rst");
        chk("rst_idle",  32'(idle), 32'd1);
        chk("rst_floor", 32'(current_floor), 32'd0);
        chk("rst_pend",  32'(pending), 32'd0);
        repeat (4) tick(8'h00, "hold");
        chk("hold_idle",  32'(idle), 32'd1);
        chk("hold_floor", 32'(current_floor), 32'd0);

        // Single call to floor 3
        tick(8'h08, "single");
        chk("single_moving", 32'(moving), 32'd1);
        chk("single_pend",   32'(pending), 32'h08);
        for (int k = 1; k <= 15; k++) begin
            tick(8'h00, "single");
            if (k == 4)  chk("single_f1", 32'(current_floor), 32'd1);
            if (k == 8)  chk("single_f2", 32'(current_floor), 32'd2);
            if (k == 12) begin
                chk("single_f3",   32'(current_floor), 32'd3);
                chk("single_door", 32'(door_open), 32'd1);
                chk("single_clr",  32'(pending), 32'h00);
            end
            if (k == 14) chk("single_dwell", 32'(door_open), 32'd1);
            if (k == 15) chk("single_idle",  32'(idle), 32'd1);
        end

        // SCAN order: going to 6, calls for 1 and 5 arrive while at floor 3
        do_reset("scan_rst");
        tick(8'h40, "scan");
        doors.delete();
        prev_door = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            tick((k == 13) ? 8'h22 : 8'h00, "scan");
            if (k == 13) chk("scan_at3", 32'(current_floor), 32'd3);
            if (door_open && !prev_door) doors.push_back(int'(current_floor));
            prev_door = door_open;
        end
        chk("scan_ndoors", 32'(doors.size()), 32'd3);
        if (doors.size() == 3) begin
            chk("scan_door0", 32'(doors[0]), 32'd5);
            chk("scan_door1", 32'(doors[1]), 32'd6);
            chk("scan_door2", 32'(doors[2]), 32'd1);
        end
        chk("scan_idle",  32'(idle), 32'd1);
        chk("scan_floor", 32'(current_floor), 32'd1);
        chk("scan_dir",   32'(dir_up), 32'd0);

        // Same-floor call and dwell restart at floor 2
        tick(8'h04, "sf");
        repeat (10) tick(8'h00, "sf");
        chk("sf_idle",  32'(idle), 32'd1);
        chk("sf_floor", 32'(current_floor), 32'd2);
        tick(8'h04, "sf_open");
        chk("sf_door",  32'(door_open), 32'd1);
        chk("sf_same",  32'(current_floor), 32'd2);
        chk("sf_pend",  32'(pending), 32'h00);
        tick(8'h00, "sf");
        tick(8'h00, "sf");
        tick(8'h04, "sf_re");
        chk("sf_re_door", 32'(door_open), 32'd1);
        chk("sf_re_pend", 32'(pending), 32'h00);
        tick(8'h00, "sf");
        tick(8'h00, "sf");
        chk("sf_still_open", 32'(door_open), 32'd1);
        tick(8'h00, "sf");
        chk("sf_closed", 32'(idle), 32'd1);

        // Extremes: floors 0 and 7 together
        do_reset("ext_rst");
        tick(8'h81, "ext");
        chk("ext_door0", 32'(door_open), 32'd1);
        chk("ext_f0",    32'(current_floor), 32'd0);
        chk("ext_pend",  32'(pending), 32'h80);
        wrapped    = 0;
        prev_floor = 0;
        for (int k = 1; k <= 40; k++) begin
            tick(8'h00, "ext");
            if (int'(current_floor) < prev_floor) wrapped = 1;
            prev_floor = int'(current_floor);
            if (k == 31) begin
                chk("ext_f7",    32'(current_floor), 32'd7);
                chk("ext_door7", 32'(door_open), 32'd1);
            end
        end
        chk("ext_no_wrap", 32'(wrapped), 32'd0);

        // Reset while travelling between 4 and 5 with calls for 0 and 6 pending
        do_reset("mm_rst0");
        tick(8'h40, "mm");
        tick(8'h00, "mm");
        tick(8'h01, "mm");
        repeat (15) tick(8'h00, "mm");
        chk("mm_pend",   32'(pending), 32'h41);
        chk("mm_floor",  32'(current_floor), 32'd4);
        chk("mm_moving", 32'(moving), 32'd1);
        do_reset("mm_rst");
        chk("mm_rst_pend",  32'(pending), 32'h00);
        chk("mm_rst_floor", 32'(current_floor), 32'd0);
        chk("mm_rst_idle",  32'(idle), 32'd1);
        repeat (8) tick(8'h00, "post");
        chk("post_idle",  32'(idle), 32'd1);
        chk("post_floor", 32'(current_floor), 32'd0);

        // Random sparse calls
        do_reset("rand_rst");
        repeat (800) begin
            r = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            tick(r, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
